// File: rtl/interleaver_bank_ctrl.sv
// ---------------------------------------------------------------------------
// interleaver_bank_ctrl
//
// Sequencing controller for the block interleaver's multi-bank bit RAM.
// Each bank holds one block of row*col entries. The write side fills one
// bank at a time in fill order. The read side drains completed banks in
// the permuted order. The sample data itself never passes through here.
//
// Parameters:
//   deepth  number of banks (blocks in flight), >= 1
//   mode    1 = interleave (write row-major, read column-major)
//           0 = de-interleave (write column-major, read row-major)
//   row     rows per block, >= 1
//   col     columns per block, >= 1
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   s_axis_tvalid  input sample valid
//   s_axis_tready  input accepted when high together with tvalid
//   wr_en          RAM write strobe
//   wr_bank        bank being filled
//   wr_addr        write address inside the bank (r*col + c)
//   rd_en          RAM read strobe (RAM registers data on rd_en, else holds)
//   rd_bank        bank being drained
//   rd_addr        read address inside the bank (r*col + c)
//   m_axis_tvalid  output sample valid (RAM output register holds data)
//   m_axis_tready  downstream ready
//   m_axis_tlast   last sample of a block
//   full_cnt       completely written banks that are not yet freed
// ---------------------------------------------------------------------------
module interleaver_bank_ctrl #(
   parameter int deepth = 4,
   parameter int mode   = 1,
   parameter int row    = 512,
   parameter int col    = 32,
   localparam int BW = (deepth > 1) ? $clog2(deepth) : 1,
   localparam int AW = (row * col > 1) ? $clog2(row * col) : 1,
   localparam int CW = $clog2(deepth + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          s_axis_tvalid,
   output logic          s_axis_tready,
   output logic          wr_en,
   output logic [BW-1:0] wr_bank,
   output logic [AW-1:0] wr_addr,
   output logic          rd_en,
   output logic [BW-1:0] rd_bank,
   output logic [AW-1:0] rd_addr,
   output logic          m_axis_tvalid,
   input  logic          m_axis_tready,
   output logic          m_axis_tlast,
   output logic [CW-1:0] full_cnt
);

   localparam int RW  = (row > 1) ? $clog2(row) : 1;
   localparam int CLW = (col > 1) ? $clog2(col) : 1;

   localparam bit WR_ROW_MAJOR = (mode != 0);
   localparam bit RD_ROW_MAJOR = (mode == 0);

   localparam logic [RW-1:0]  R_LAST    = RW'(row - 1);
   localparam logic [CLW-1:0] C_LAST    = CLW'(col - 1);
   localparam logic [BW-1:0]  BANK_LAST = BW'(deepth - 1);
   localparam logic [AW-1:0]  ADDR_COL  = AW'(col);

   logic [RW-1:0]  wr_r;
   logic [RW-1:0]  rd_r;
   logic [CLW-1:0] wr_c;
   logic [CLW-1:0] rd_c;
   logic           wr_last;
   logic           rd_last;
   logic           wr_done;
   logic           rd_done;

   // Handshakes. Both strobes depend only on registered state plus the
   // incoming valid/ready, so no combinational loop exists through the RAM.
   always_comb begin
      s_axis_tready = (full_cnt < CW'(deepth));
      wr_en         = s_axis_tvalid && s_axis_tready;
      rd_en         = (full_cnt != '0) && (!m_axis_tvalid || m_axis_tready);
      // Both scan orders end at (row-1, col-1), whichever index runs fastest.
      wr_last       = (wr_r == R_LAST) && (wr_c == C_LAST);
      rd_last       = (rd_r == R_LAST) && (rd_c == C_LAST);
      wr_done       = wr_en && wr_last;
      rd_done       = rd_en && rd_last;
   end

   // Write counters. The address is tracked incrementally instead of
   // multiplying r*col: row-major steps by 1, column-major steps by col and
   // restarts at the next column index when the row index wraps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_r    <= '0;
         wr_c    <= '0;
         wr_addr <= '0;
         wr_bank <= '0;
      end else if (wr_en) begin
         if (wr_last) begin
            wr_r    <= '0;
            wr_c    <= '0;
            wr_addr <= '0;
            wr_bank <= (wr_bank == BANK_LAST) ? '0 : wr_bank + BW'(1);
         end else if (WR_ROW_MAJOR) begin
            wr_addr <= wr_addr + AW'(1);
            if (wr_c == C_LAST) begin
               wr_c <= '0;
               wr_r <= wr_r + RW'(1);
            end else begin
               wr_c <= wr_c + CLW'(1);
            end
         end else begin
            if (wr_r == R_LAST) begin
               wr_r    <= '0;
               wr_c    <= wr_c + CLW'(1);
               wr_addr <= AW'(wr_c) + AW'(1);
            end else begin
               wr_r    <= wr_r + RW'(1);
               wr_addr <= wr_addr + ADDR_COL;
            end
         end
      end
   end

   // Read counters, same scheme as the write side with the opposite order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_r    <= '0;
         rd_c    <= '0;
         rd_addr <= '0;
         rd_bank <= '0;
      end else if (rd_en) begin
         if (rd_last) begin
            rd_r    <= '0;
            rd_c    <= '0;
            rd_addr <= '0;
            rd_bank <= (rd_bank == BANK_LAST) ? '0 : rd_bank + BW'(1);
         end else if (RD_ROW_MAJOR) begin
            rd_addr <= rd_addr + AW'(1);
            if (rd_c == C_LAST) begin
               rd_c <= '0;
               rd_r <= rd_r + RW'(1);
            end else begin
               rd_c <= rd_c + CLW'(1);
            end
         end else begin
            if (rd_r == R_LAST) begin
               rd_r    <= '0;
               rd_c    <= rd_c + CLW'(1);
               rd_addr <= AW'(rd_c) + AW'(1);
            end else begin
               rd_r    <= rd_r + RW'(1);
               rd_addr <= rd_addr + ADDR_COL;
            end
         end
      end
   end

   // Occupancy. A bank is freed on its final read strobe because the RAM
   // output register already owns that sample, so the writer may reuse the
   // bank immediately. A fill and a free in the same cycle cancel out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_cnt <= '0;
      end else if (wr_done && !rd_done) begin
         full_cnt <= full_cnt + CW'(1);
      end else if (rd_done && !wr_done) begin
         full_cnt <= full_cnt - CW'(1);
      end
   end

   // Output valid/last mirror the RAM output register: loaded on every read
   // strobe, dropped once the downstream takes the sample with nothing new
   // behind it, held untouched during a downstream stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
      end else if (rd_en) begin
         m_axis_tvalid <= 1'b1;
         m_axis_tlast  <= rd_last;
      end else if (m_axis_tready) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_interleaver_bank_ctrl.sv
// ---------------------------------------------------------------------------
// tb_interleaver_bank_ctrl
//
// Directed bench for interleaver_bank_ctrl with deepth=2, row=2, col=3.
// Two instances share the stimulus: u_int (mode=1) and u_dei (mode=0).
// A negedge monitor logs strobes/addresses; expected sequences are
// hand-computed tables.
// ---------------------------------------------------------------------------
module tb_interleaver_bank_ctrl;

   logic       clk;
   logic       rst_n;
   logic       s_axis_tvalid;
   logic       m_axis_tready;

   logic       s_tready_i, wr_en_i, rd_en_i, m_tvalid_i, m_tlast_i;
   logic [0:0] wr_bank_i, rd_bank_i;
   logic [2:0] wr_addr_i, rd_addr_i;
   logic [1:0] full_cnt_i;

   logic       s_tready_d, wr_en_d, rd_en_d, m_tvalid_d, m_tlast_d;
   logic [0:0] wr_bank_d, rd_bank_d;
   logic [2:0] wr_addr_d, rd_addr_d;
   logic [1:0] full_cnt_d;

   int check_count = 0;
   int pass_count  = 0;
   int cyc         = 0;

   int wa_i[$], wb_i[$], wcyc_i[$], wfc_i[$];
   int ra_i[$], rb_i[$], tl_i[$];
   int wa_d[$], ra_d[$];
   int stall_err = 0;
   int tv_first  = -1;

   int row_order[$] = '{0, 1, 2, 3, 4, 5};
   int col_order[$] = '{0, 3, 1, 4, 2, 5};
   int last_flags[$] = '{0, 0, 0, 0, 0, 1};

   interleaver_bank_ctrl #(.deepth(2), .mode(1), .row(2), .col(3)) u_int (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_tready_i),
      .wr_en(wr_en_i), .wr_bank(wr_bank_i), .wr_addr(wr_addr_i),
      .rd_en(rd_en_i), .rd_bank(rd_bank_i), .rd_addr(rd_addr_i),
      .m_axis_tvalid(m_tvalid_i), .m_axis_tready(m_axis_tready),
      .m_axis_tlast(m_tlast_i), .full_cnt(full_cnt_i)
   );

   interleaver_bank_ctrl #(.deepth(2), .mode(0), .row(2), .col(3)) u_dei (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_tready_d),
      .wr_en(wr_en_d), .wr_bank(wr_bank_d), .wr_addr(wr_addr_d),
      .rd_en(rd_en_d), .rd_bank(rd_bank_d), .rd_addr(rd_addr_d),
      .m_axis_tvalid(m_tvalid_d), .m_axis_tready(m_axis_tready),
      .m_axis_tlast(m_tlast_d), .full_cnt(full_cnt_d)
   );

   // Free-running clock and cycle counter used to timestamp events.
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor sampling mid-cycle, when strobes for the coming edge are stable.
   always @(negedge clk) begin
      if (rst_n) begin
         if (wr_en_i) begin
            wa_i.push_back(int'(wr_addr_i));
            wb_i.push_back(int'(wr_bank_i));
            wcyc_i.push_back(cyc);
            wfc_i.push_back(int'(full_cnt_i));
         end
         if (rd_en_i) begin
            ra_i.push_back(int'(rd_addr_i));
            rb_i.push_back(int'(rd_bank_i));
         end
         if (rd_en_i && m_tvalid_i && !m_axis_tready) stall_err++;
         if (m_tvalid_i && m_axis_tready) tl_i.push_back(int'(m_tlast_i));
         if (m_tvalid_i && tv_first < 0) tv_first = cyc;
         if (wr_en_d) wa_d.push_back(int'(wr_addr_d));
         if (rd_en_d) ra_d.push_back(int'(rd_addr_d));
      end
   end

   task automatic checkOutput(input string tag, input int observed, input int expected);
      check_count++;
      if (observed == expected) pass_count++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
   endtask

   task automatic checkSeq(input string tag, input int got[$], input int exp_q[$]);
      checkOutput({tag, "_len"}, got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         checkOutput($sformatf("%s[%0d]", tag, i), (i < got.size()) ? got[i] : -1, exp_q[i]);
   endtask

   task automatic clearLog();
      wa_i.delete(); wb_i.delete(); wcyc_i.delete(); wfc_i.delete();
      ra_i.delete(); rb_i.delete(); tl_i.delete();
      wa_d.delete(); ra_d.delete();
      stall_err = 0;
      tv_first  = -1;
   endtask

   task automatic doReset();
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      clearLog();
   endtask

   // Holds s_axis_tvalid until n more samples have been accepted.
   task automatic applyStimulus(input int n);
      int target;
      bit done;
      target = wa_i.size() + n;
      done = 1'b0;
      @(posedge clk);
      #1 s_axis_tvalid = 1'b1;
      for (int k = 0; k < 1000 && !done; k++) begin
         @(posedge clk);
         #1;
         if (wa_i.size() >= target) done = 1'b1;
      end
      s_axis_tvalid = 1'b0;
      if (!done) checkOutput("send_timeout", wa_i.size(), target);
   endtask

   // One block with the output always ready, checked in both modes.
   task automatic runBasic(input string tag);
      clearLog();
      m_axis_tready = 1'b1;
      applyStimulus(6);
      repeat (12) @(posedge clk);
      #1;
      checkSeq({tag, "_int_wr"}, wa_i, row_order);
      checkSeq({tag, "_int_rd"}, ra_i, col_order);
      checkSeq({tag, "_int_last"}, tl_i, last_flags);
      checkSeq({tag, "_dei_wr"}, wa_d, col_order);
      checkSeq({tag, "_dei_rd"}, ra_d, row_order);
      checkOutput({tag, "_wr_bank"}, wb_i[0], 0);
      checkOutput({tag, "_rd_bank"}, (rb_i.size() > 0) ? rb_i[0] : -1, 0);
      checkOutput({tag, "_latency"}, tv_first - wcyc_i[5], 2);
      checkOutput({tag, "_full_end"}, int'(full_cnt_i), 0);
      checkOutput({tag, "_tvalid_end"}, int'(m_tvalid_i), 0);
   endtask

   initial begin
      int bound;
      rst_n = 1'b0;
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b1;
      #1;
      // Reset state
      checkOutput("rst_wr_en", int'(wr_en_i), 0);
      checkOutput("rst_rd_en", int'(rd_en_i), 0);
      checkOutput("rst_tvalid", int'(m_tvalid_i), 0);
      checkOutput("rst_tlast", int'(m_tlast_i), 0);
      checkOutput("rst_full", int'(full_cnt_i), 0);
      checkOutput("rst_wr_addr", int'(wr_addr_i), 0);
      checkOutput("rst_rd_addr", int'(rd_addr_i), 0);
      checkOutput("rst_s_tready", int'(s_tready_i), 1);
      doReset();

      // Scenarios 1 and 2: single block, both modes
      runBasic("basic");

      // Scenario 3: downstream never ready
      doReset();
      m_axis_tready = 1'b0;
      @(posedge clk);
      #1 s_axis_tvalid = 1'b1;
      repeat (16) @(posedge clk);
      #1 s_axis_tvalid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("stall_writes", wa_i.size(), 12);
      checkOutput("stall_full", int'(full_cnt_i), 2);
      checkOutput("stall_s_tready", int'(s_tready_i), 0);
      checkOutput("stall_tvalid", int'(m_tvalid_i), 1);
      checkOutput("stall_reads", ra_i.size(), 1);
      checkOutput("stall_rd_addr", int'(rd_addr_i), 3);
      checkOutput("stall_rd_en", int'(rd_en_i), 0);

      // Scenario 4: random downstream stalls over three blocks
      doReset();
      fork
         applyStimulus(18);
         begin
            bound = 0;
            while (tl_i.size() < 18 && bound < 2000) begin
               @(posedge clk);
               #1 m_axis_tready = ($urandom_range(0, 2) != 0);
               bound++;
            end
            m_axis_tready = 1'b1;
            if (bound >= 2000) checkOutput("rand_timeout", tl_i.size(), 18);
         end
      join
      repeat (4) @(posedge clk);
      #1;
      checkSeq("rand_rd", ra_i, {col_order, col_order, col_order});
      checkSeq("rand_last", tl_i, {last_flags, last_flags, last_flags});
      checkOutput("rand_stall_rd", stall_err, 0);
      checkOutput("rand_wbank0", wb_i[0], 0);
      checkOutput("rand_wbank1", wb_i[6], 1);
      checkOutput("rand_wbank2", wb_i[12], 0);
      checkOutput("rand_rbank0", (rb_i.size() > 0) ? rb_i[0] : -1, 0);
      checkOutput("rand_rbank1", (rb_i.size() > 6) ? rb_i[6] : -1, 1);
      checkOutput("rand_rbank2", (rb_i.size() > 12) ? rb_i[12] : -1, 0);

      // Scenario 5: continuous streaming, completions coincide
      doReset();
      applyStimulus(18);
      repeat (10) @(posedge clk);
      #1;
      checkOutput("stream_no_bubble", wcyc_i[17] - wcyc_i[0], 17);
      checkOutput("stream_full_b1", wfc_i[6], 1);
      checkOutput("stream_full_b2", wfc_i[12], 1);
      checkOutput("stream_outputs", tl_i.size(), 18);
      checkOutput("stream_full_end", int'(full_cnt_i), 0);

      // Scenario 6: reset in the middle of a block
      doReset();
      applyStimulus(4);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midrst_wr_addr", int'(wr_addr_i), 0);
      checkOutput("midrst_wr_en", int'(wr_en_i), 0);
      checkOutput("midrst_full", int'(full_cnt_i), 0);
      checkOutput("midrst_tvalid", int'(m_tvalid_i), 0);
      checkOutput("midrst_dei_wr_addr", int'(wr_addr_d), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      runBasic("after_rst");

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
